// File: rtl/sprite_compositor.sv
// Sprite compositor: tests each pixel against up to eight circle/square objects
// latched at frame start, resolves overlaps by index priority, 3-stage pipeline.
module sprite_compositor #(
    parameter int N_OBJ     = 4,
    parameter int COORD_W   = 10,
    parameter int BLINK_BIT = 4
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          frame_start,
    input  logic                          pix_valid,
    input  logic [COORD_W-1:0]            DrawX,
    input  logic [COORD_W-1:0]            DrawY,
    input  logic [N_OBJ-1:0][COORD_W-1:0] ObjX,
    input  logic [N_OBJ-1:0][COORD_W-1:0] ObjY,
    input  logic [N_OBJ-1:0][COORD_W-1:0] ObjSize,
    input  logic [N_OBJ-1:0][23:0]        ObjColor,
    input  logic [N_OBJ-1:0]              ObjEn,
    input  logic [N_OBJ-1:0]              ObjShape,
    input  logic [N_OBJ-1:0]              ObjBlink,
    output logic [7:0]                    Red,
    output logic [7:0]                    Green,
    output logic [7:0]                    Blue,
    output logic                          rgb_valid,
    output logic                          hit,
    output logic [2:0]                    hit_idx
);

    localparam int D_W  = COORD_W + 1;
    localparam int SQ_W = 2 * COORD_W + 3;

    logic [N_OBJ-1:0][COORD_W-1:0] r_shX, r_shY, r_shSize;
    logic [N_OBJ-1:0][23:0]        r_shColor;
    logic [N_OBJ-1:0]              r_shEn, r_shShape, r_shBlink;
    logic [7:0]                    r_frameCnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_shX      <= '0;
            r_shY      <= '0;
            r_shSize   <= '0;
            r_shColor  <= '0;
            r_shEn     <= '0;
            r_shShape  <= '0;
            r_shBlink  <= '0;
            r_frameCnt <= '0;
        end else if (frame_start) begin
            r_shX      <= ObjX;
            r_shY      <= ObjY;
            r_shSize   <= ObjSize;
            r_shColor  <= ObjColor;
            r_shEn     <= ObjEn;
            r_shShape  <= ObjShape;
            r_shBlink  <= ObjBlink;
            r_frameCnt <= r_frameCnt + 8'd1;
        end
    end

    // Stage 1: per-object attributes travel with the pixel so a later reload cannot tear it.
    logic signed [COORD_W:0] w_dx [N_OBJ];
    logic signed [COORD_W:0] w_dy [N_OBJ];
    logic [N_OBJ-1:0]        w_vis;
    logic [7:0]              w_bgRed;

    always_comb begin
        w_vis   = '0;
        w_bgRed = 8'h4F - 8'(DrawX >> 3);
        for (int i = 0; i < N_OBJ; i++) begin
            w_dx[i]  = $signed({1'b0, DrawX}) - $signed({1'b0, r_shX[i]});
            w_dy[i]  = $signed({1'b0, DrawY}) - $signed({1'b0, r_shY[i]});
            w_vis[i] = r_shEn[i] & (~r_shBlink[i] | ~r_frameCnt[BLINK_BIT]);
        end
    end

    logic                          r1_valid;
    logic signed [COORD_W:0]       r1_dx [N_OBJ];
    logic signed [COORD_W:0]       r1_dy [N_OBJ];
    logic [N_OBJ-1:0]              r1_vis, r1_shape;
    logic [N_OBJ-1:0][COORD_W-1:0] r1_size;
    logic [N_OBJ-1:0][23:0]        r1_color;
    logic [7:0]                    r1_bgRed;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r1_valid <= 1'b0;
            r1_vis   <= '0;
            r1_shape <= '0;
            r1_size  <= '0;
            r1_color <= '0;
            r1_bgRed <= '0;
            for (int i = 0; i < N_OBJ; i++) begin
                r1_dx[i] <= '0;
                r1_dy[i] <= '0;
            end
        end else begin
            r1_valid <= pix_valid;
            r1_vis   <= w_vis;
            r1_shape <= r_shShape;
            r1_size  <= r_shSize;
            r1_color <= r_shColor;
            r1_bgRed <= w_bgRed;
            for (int i = 0; i < N_OBJ; i++) begin
                r1_dx[i] <= w_dx[i];
                r1_dy[i] <= w_dy[i];
            end
        end
    end

    logic [D_W-1:0]  w_absDx  [N_OBJ];
    logic [D_W-1:0]  w_absDy  [N_OBJ];
    logic [SQ_W-1:0] w_sumSq  [N_OBJ];
    logic [SQ_W-1:0] w_sizeSq [N_OBJ];

    always_comb begin
        for (int i = 0; i < N_OBJ; i++) begin
            w_absDx[i]  = r1_dx[i][COORD_W] ? $unsigned(-r1_dx[i]) : $unsigned(r1_dx[i]);
            w_absDy[i]  = r1_dy[i][COORD_W] ? $unsigned(-r1_dy[i]) : $unsigned(r1_dy[i]);
            w_sumSq[i]  = SQ_W'(w_absDx[i]) * SQ_W'(w_absDx[i])
                        + SQ_W'(w_absDy[i]) * SQ_W'(w_absDy[i]);
            w_sizeSq[i] = SQ_W'(r1_size[i]) * SQ_W'(r1_size[i]);
        end
    end

    logic                          r2_valid;
    logic [D_W-1:0]                r2_absDx  [N_OBJ];
    logic [D_W-1:0]                r2_absDy  [N_OBJ];
    logic [SQ_W-1:0]               r2_sumSq  [N_OBJ];
    logic [SQ_W-1:0]               r2_sizeSq [N_OBJ];
    logic [N_OBJ-1:0]              r2_vis, r2_shape;
    logic [N_OBJ-1:0][COORD_W-1:0] r2_size;
    logic [N_OBJ-1:0][23:0]        r2_color;
    logic [7:0]                    r2_bgRed;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r2_valid <= 1'b0;
            r2_vis   <= '0;
            r2_shape <= '0;
            r2_size  <= '0;
            r2_color <= '0;
            r2_bgRed <= '0;
            for (int i = 0; i < N_OBJ; i++) begin
                r2_absDx[i]  <= '0;
                r2_absDy[i]  <= '0;
                r2_sumSq[i]  <= '0;
                r2_sizeSq[i] <= '0;
            end
        end else begin
            r2_valid <= r1_valid;
            r2_vis   <= r1_vis;
            r2_shape <= r1_shape;
            r2_size  <= r1_size;
            r2_color <= r1_color;
            r2_bgRed <= r1_bgRed;
            for (int i = 0; i < N_OBJ; i++) begin
                r2_absDx[i]  <= w_absDx[i];
                r2_absDy[i]  <= w_absDy[i];
                r2_sumSq[i]  <= w_sumSq[i];
                r2_sizeSq[i] <= w_sizeSq[i];
            end
        end
    end

    // Scanning from the highest index down lets the lowest covering index win.
    logic [N_OBJ-1:0] w_cover;
    logic             w_hit;
    logic [2:0]       w_idx;
    logic [23:0]      w_rgb;

    always_comb begin
        w_cover = '0;
        w_hit   = 1'b0;
        w_idx   = 3'd0;
        w_rgb   = {r2_bgRed, 8'h00, 8'h44};
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (r2_shape[i])
                w_cover[i] = r2_vis[i] && (r2_absDx[i] <= {1'b0, r2_size[i]})
                                       && (r2_absDy[i] <= {1'b0, r2_size[i]});
            else
                w_cover[i] = r2_vis[i] && (r2_sumSq[i] <= r2_sizeSq[i]);
            if (w_cover[i]) begin
                w_hit = 1'b1;
                w_idx = 3'(i);
                w_rgb = r2_color[i];
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rgb_valid <= 1'b0;
            Red       <= '0;
            Green     <= '0;
            Blue      <= '0;
            hit       <= 1'b0;
            hit_idx   <= '0;
        end else begin
            rgb_valid <= r2_valid;
            if (r2_valid) begin
                {Red, Green, Blue} <= w_rgb;
                hit     <= w_hit;
                hit_idx <= w_idx;
            end
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenarios plus a randomized stream, all
// checked against a coordinate-arithmetic model of the compositing rules.
module tb_sprite_compositor;

    localparam int N_OBJ     = 4;
    localparam int COORD_W   = 10;
    localparam int BLINK_BIT = 4;
    localparam int CMAX      = (1 << COORD_W) - 1;

    logic                          Clk = 1'b0;
    logic                          Reset;
    logic                          frame_start;
    logic                          pix_valid;
    logic [COORD_W-1:0]            DrawX, DrawY;
    logic [N_OBJ-1:0][COORD_W-1:0] ObjX, ObjY, ObjSize;
    logic [N_OBJ-1:0][23:0]        ObjColor;
    logic [N_OBJ-1:0]              ObjEn, ObjShape, ObjBlink;
    logic [7:0]                    Red, Green, Blue;
    logic                          rgb_valid, hit;
    logic [2:0]                    hit_idx;

    sprite_compositor #(.N_OBJ(N_OBJ), .COORD_W(COORD_W), .BLINK_BIT(BLINK_BIT)) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .ObjX(ObjX), .ObjY(ObjY), .ObjSize(ObjSize),
        .ObjColor(ObjColor), .ObjEn(ObjEn), .ObjShape(ObjShape), .ObjBlink(ObjBlink),
        .Red(Red), .Green(Green), .Blue(Blue), .rgb_valid(rgb_valid), .hit(hit),
        .hit_idx(hit_idx)
    );

    always #5 Clk = ~Clk;

    // Reference model: the object set as last latched, plus the frame count.
    logic [N_OBJ-1:0][COORD_W-1:0] mX, mY, mSize;
    logic [N_OBJ-1:0][23:0]        mColor;
    logic [N_OBJ-1:0]              mEn, mShape, mBlink;
    int                            mFrame;
    int                            nVec = 0;
    int                            nErr = 0;

    function automatic logic [27:0] refPixel(input int x, input int y);
        logic [27:0] r;
        bit          found, cov, vis;
        int          dx, dy, s;
        r     = {1'b0, 3'd0, 8'(int'(8'h4F) - x / 8), 8'h00, 8'h44};
        found = 0;
        for (int i = 0; i < N_OBJ; i++) begin
            dx  = x - int'(mX[i]);
            dy  = y - int'(mY[i]);
            s   = int'(mSize[i]);
            if (mShape[i]) cov = ((dx < 0 ? -dx : dx) <= s) && ((dy < 0 ? -dy : dy) <= s);
            else           cov = (dx * dx + dy * dy) <= s * s;
            vis = mEn[i] && (!mBlink[i] || ((mFrame / (1 << BLINK_BIT)) % 2 == 0));
            if (!found && vis && cov) begin
                r     = {1'b1, 3'(i), mColor[i]};
                found = 1;
            end
        end
        return r;
    endfunction

    function automatic void latchModel();
        mX = ObjX; mY = ObjY; mSize = ObjSize; mColor = ObjColor;
        mEn = ObjEn; mShape = ObjShape; mBlink = ObjBlink;
        mFrame = (mFrame + 1) % 256;
    endfunction

    function automatic void resetModel();
        mX = '0; mY = '0; mSize = '0; mColor = '0;
        mEn = '0; mShape = '0; mBlink = '0;
        mFrame = 0;
    endfunction

    task automatic clearObjs();
        ObjX = '0; ObjY = '0; ObjSize = '0; ObjColor = '0;
        ObjEn = '0; ObjShape = '0; ObjBlink = '0;
    endtask

    task automatic setObj(input int i, input int x, input int y, input int s,
                          input logic [23:0] c, input logic en, input logic sh, input logic bl);
        ObjX[i] = COORD_W'(x); ObjY[i] = COORD_W'(y); ObjSize[i] = COORD_W'(s);
        ObjColor[i] = c; ObjEn[i] = en; ObjShape[i] = sh; ObjBlink[i] = bl;
    endtask

    task automatic doReset();
        Reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b0;
        resetModel();
    endtask

    task automatic loadFrame();
        frame_start = 1'b1;
        @(posedge Clk); #1;
        frame_start = 1'b0;
        latchModel();
    endtask

    // Sends one pixel (optionally with a coincident frame_start) and captures the result.
    task automatic probe(input int x, input int y, input logic fs,
                         output logic [27:0] got, output logic early, output logic vld);
        DrawX = COORD_W'(x); DrawY = COORD_W'(y); pix_valid = 1'b1; frame_start = fs;
        @(posedge Clk); #1;
        pix_valid = 1'b0; frame_start = 1'b0;
        if (fs) latchModel();
        @(posedge Clk); #1;
        early = rgb_valid;
        @(posedge Clk); #1;
        vld = rgb_valid;
        got = {hit, hit_idx, Red, Green, Blue};
    endtask

    task automatic test_reset();
        logic [27:0] got, exp;
        logic        early, vld;
        @(posedge Clk); #1;
        nVec++;
        if ({rgb_valid, hit, hit_idx, Red, Green, Blue} !== 29'd0) begin
            nErr++;
            $display("[TB] FAIL reset_state: got %h, want 0",
                     {rgb_valid, hit, hit_idx, Red, Green, Blue});
        end
        Reset = 1'b0;
        resetModel();
        exp = refPixel(108, 107);
        probe(108, 107, 1'b0, got, early, vld);
        nVec++;
        if ({vld, early, got} !== {1'b1, 1'b0, exp}) begin
            nErr++;
            $display("[TB] FAIL reset_background: got vld=%b early=%b out=%h, want vld=1 early=0 out=%h",
                     vld, early, got, exp);
        end
    endtask

    task automatic test_circle();
        int          px[4] = '{110, 108, 108, 92};
        int          py[4] = '{100, 106, 107, 100};
        logic [27:0] got, exp;
        logic        early, vld;
        clearObjs();
        setObj(0, 100, 100, 10, 24'hFF0000, 1'b1, 1'b0, 1'b0);
        loadFrame();
        for (int k = 0; k < 4; k++) begin
            exp = refPixel(px[k], py[k]);
            probe(px[k], py[k], 1'b0, got, early, vld);
            nVec++;
            if ({vld, early, got} !== {1'b1, 1'b0, exp}) begin
                nErr++;
                $display("[TB] FAIL circle(%0d,%0d): got vld=%b early=%b out=%h, want vld=1 early=0 out=%h",
                         px[k], py[k], vld, early, got, exp);
            end
        end
    endtask

    task automatic test_square();
        int          px[4] = '{0, 14, 13, 5};
        int          py[4] = '{0, 5, 13, 14};
        logic [27:0] got, exp;
        logic        early, vld;
        clearObjs();
        setObj(0, 5, 5, 8, 24'h123456, 1'b1, 1'b1, 1'b0);
        loadFrame();
        for (int k = 0; k < 4; k++) begin
            exp = refPixel(px[k], py[k]);
            probe(px[k], py[k], 1'b0, got, early, vld);
            nVec++;
            if ({vld, early, got} !== {1'b1, 1'b0, exp}) begin
                nErr++;
                $display("[TB] FAIL square(%0d,%0d): got vld=%b early=%b out=%h, want vld=1 early=0 out=%h",
                         px[k], py[k], vld, early, got, exp);
            end
        end
    endtask

    task automatic test_priority();
        logic [27:0] got, exp;
        logic        early, vld;
        clearObjs();
        setObj(0, 50, 50, 5, 24'h00FF00, 1'b1, 1'b0, 1'b0);
        setObj(2, 52, 50, 5, 24'h0000FF, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            if (k == 1) ObjEn[0] = 1'b0;
            loadFrame();
            exp = refPixel(50, 50);
            probe(50, 50, 1'b0, got, early, vld);
            nVec++;
            if ({vld, early, got} !== {1'b1, 1'b0, exp}) begin
                nErr++;
                $display("[TB] FAIL priority_%0d: got vld=%b early=%b out=%h, want vld=1 early=0 out=%h",
                         k, vld, early, got, exp);
            end
        end
    endtask

    task automatic test_shadow();
        int          px[5] = '{200, 400, 200, 200, 400};
        logic        fs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [27:0] got, exp;
        logic        early, vld;
        clearObjs();
        setObj(0, 200, 200, 10, 24'hABCDEF, 1'b1, 1'b0, 1'b0);
        loadFrame();
        ObjX[0] = COORD_W'(400);
        for (int k = 0; k < 5; k++) begin
            exp = refPixel(px[k], 200);
            probe(px[k], 200, fs[k], got, early, vld);
            nVec++;
            if ({vld, early, got} !== {1'b1, 1'b0, exp}) begin
                nErr++;
                $display("[TB] FAIL shadow_%0d(%0d,200): got vld=%b early=%b out=%h, want vld=1 early=0 out=%h",
                         k, px[k], vld, early, got, exp);
            end
        end
    endtask

    task automatic test_extremes();
        int          px[5] = '{0, 0, CMAX, CMAX, 512};
        int          py[5] = '{0, CMAX, 0, CMAX, 511};
        logic [27:0] got, exp;
        logic        early, vld;
        clearObjs();
        setObj(0, CMAX, 0, CMAX, 24'h111111, 1'b1, 1'b0, 1'b0);
        setObj(1, 0, CMAX, CMAX, 24'h222222, 1'b1, 1'b1, 1'b0);
        setObj(2, 0, 0, CMAX, 24'h333333, 1'b1, 1'b0, 1'b0);
        setObj(3, CMAX, CMAX, 0, 24'h444444, 1'b1, 1'b1, 1'b0);
        loadFrame();
        for (int k = 0; k < 5; k++) begin
            exp = refPixel(px[k], py[k]);
            probe(px[k], py[k], 1'b0, got, early, vld);
            nVec++;
            if ({vld, early, got} !== {1'b1, 1'b0, exp}) begin
                nErr++;
                $display("[TB] FAIL extreme(%0d,%0d): got vld=%b early=%b out=%h, want vld=1 early=0 out=%h",
                         px[k], py[k], vld, early, got, exp);
            end
        end
    endtask

    task automatic test_blink();
        logic [27:0] got, exp;
        logic        early, vld;
        clearObjs();
        setObj(0, 300, 300, 20, 24'hC0FFEE, 1'b1, 1'b0, 1'b1);
        setObj(1, 300, 300, 20, 24'h0BADF0, 1'b1, 1'b1, 1'b0);
        for (int f = 0; f < 300; f++) begin
            loadFrame();
            exp = refPixel(300, 300);
            probe(300, 300, 1'b0, got, early, vld);
            nVec++;
            if ({vld, early, got} !== {1'b1, 1'b0, exp}) begin
                nErr++;
                $display("[TB] FAIL blink_frame%0d: got vld=%b early=%b out=%h, want vld=1 early=0 out=%h",
                         mFrame, vld, early, got, exp);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [27:0] got, exp;
        logic        early, vld, stale;
        clearObjs();
        setObj(0, 100, 100, 10, 24'hFF0000, 1'b1, 1'b0, 1'b0);
        loadFrame();
        exp = refPixel(100, 100);
        DrawX = COORD_W'(100); DrawY = COORD_W'(100); pix_valid = 1'b1;
        repeat (3) begin @(posedge Clk); #1; end
        nVec++;
        if ({rgb_valid, hit, hit_idx, Red, Green, Blue} !== {1'b1, exp}) begin
            nErr++;
            $display("[TB] FAIL pre_reset_pixel: got %h, want %h",
                     {rgb_valid, hit, hit_idx, Red, Green, Blue}, {1'b1, exp});
        end
        pix_valid = 1'b0;
        Reset = 1'b1;
        #1;
        nVec++;
        if ({rgb_valid, hit, hit_idx, Red, Green, Blue} !== 29'd0) begin
            nErr++;
            $display("[TB] FAIL midstream_reset_clear: got %h, want 0",
                     {rgb_valid, hit, hit_idx, Red, Green, Blue});
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        resetModel();
        stale = 1'b0;
        repeat (5) begin
            @(posedge Clk); #1;
            if (rgb_valid) stale = 1'b1;
        end
        nVec++;
        if (stale !== 1'b0) begin
            nErr++;
            $display("[TB] FAIL midstream_stale: got rgb_valid seen=%b, want 0", stale);
        end
        exp = refPixel(100, 100);
        probe(100, 100, 1'b0, got, early, vld);
        nVec++;
        if ({vld, early, got} !== {1'b1, 1'b0, exp}) begin
            nErr++;
            $display("[TB] FAIL post_reset_pixel: got vld=%b early=%b out=%h, want vld=1 early=0 out=%h",
                     vld, early, got, exp);
        end
    endtask

    task automatic randObjs();
        for (int i = 0; i < N_OBJ; i++) begin
            ObjX[i]     = COORD_W'($urandom_range(0, CMAX));
            ObjY[i]     = COORD_W'($urandom_range(0, CMAX));
            ObjSize[i]  = ($urandom_range(0, 7) == 0) ? COORD_W'($urandom_range(0, CMAX))
                                                      : COORD_W'($urandom_range(0, 80));
            ObjColor[i] = 24'($urandom);
            ObjEn[i]    = ($urandom_range(0, 3) != 0);
            ObjShape[i] = 1'($urandom_range(0, 1));
            ObjBlink[i] = ($urandom_range(0, 4) == 0);
        end
    endtask

    task automatic test_back_to_back();
        logic [28:0] q[$];
        logic [28:0] ent;
        logic [27:0] lastExp;
        logic        fs, pv;
        int          x, y, j;
        doReset();
        randObjs();
        lastExp = '0;
        for (int k = 0; k < 3003; k++) begin
            if (q.size() == 3) begin
                ent = q.pop_front();
                if (ent[28]) lastExp = ent[27:0];
                nVec++;
                if ({rgb_valid, hit, hit_idx, Red, Green, Blue} !== {ent[28], lastExp}) begin
                    nErr++;
                    $display("[TB] FAIL stream_cycle%0d: got %h, want %h", k,
                             {rgb_valid, hit, hit_idx, Red, Green, Blue}, {ent[28], lastExp});
                end
            end
            if ($urandom_range(0, 9) == 0) randObjs();
            fs = (k < 3000) && (k == 0 || $urandom_range(0, 40) == 0);
            pv = (k < 3000) && ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 0) begin
                j = int'($urandom_range(0, N_OBJ - 1));
                x = int'(mX[j]) + int'($urandom_range(0, 120)) - 60;
                y = int'(mY[j]) + int'($urandom_range(0, 120)) - 60;
            end else begin
                x = int'($urandom_range(0, CMAX));
                y = int'($urandom_range(0, CMAX));
            end
            x = (x < 0) ? 0 : (x > CMAX) ? CMAX : x;
            y = (y < 0) ? 0 : (y > CMAX) ? CMAX : y;
            DrawX = COORD_W'(x); DrawY = COORD_W'(y);
            pix_valid = pv; frame_start = fs;
            ent = pv ? {1'b1, refPixel(x, y)} : 29'd0;
            q.push_back(ent);
            if (fs) latchModel();
            @(posedge Clk); #1;
        end
        pix_valid = 1'b0; frame_start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        Reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
        DrawX = '0; DrawY = '0;
        clearObjs();
        resetModel();
        test_reset();
        test_circle();
        test_square();
        test_priority();
        test_shadow();
        test_extremes();
        test_blink();
        test_reset_midstream();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
